// File: rtl/cache_ctrl_nway_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the N-way cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Controller state encoding, 4 bits wide to leave room for later states.
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_COMPARE     = 4'd1,
        ST_WRITE_BACK  = 4'd2,
        ST_REFILL_REQ  = 4'd3,
        ST_REFILL_DATA = 4'd4,
        ST_REFILL_DONE = 4'd5,
        ST_WRITE_THRU  = 4'd6
    } cache_state_t;

    // Values driven on mem_req_we.
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_nway_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : cache_victim_sel
// Description : Victim way chooser. Picks the lowest-index invalid way; when
//               every way is valid it uses a round-robin pointer instead.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_victim_sel #(
    parameter int WAYS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WAYS-1:0] valid_way,
    input  logic            advance,
    output logic [WAYS-1:0] victim
);

    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [PW-1:0]   r_rr_ptr;
    logic [WAYS-1:0] w_first_inv;
    logic [WAYS-1:0] w_rr_hot;
    logic            w_all_valid;

    assign w_all_valid = &valid_way;
    // Isolates the lowest zero bit of valid_way as a one-hot vector.
    assign w_first_inv = ~valid_way & (valid_way + WAYS'(1));

    // One-hot decode of the round-robin pointer.
    always_comb begin
        w_rr_hot = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_rr_hot[i] = (r_rr_ptr == PW'(i));
        end
    end

    assign victim = w_all_valid ? w_rr_hot : w_first_inv;

    // Pointer only moves when it was actually used to choose the victim.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (advance && w_all_valid) begin
            if (r_rr_ptr == PW'(WAYS - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= r_rr_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_nway
// Description : N-way set-associative cache controller FSM with multi-beat
//               line transfers and write-back / write-through policy.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_nway
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int BEATS      = 4,
    parameter int WRITE_BACK = 1,
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_type,
    output logic            req_ready,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] valid_way,
    input  logic [WAYS-1:0] dirty_way,
    output logic [WAYS-1:0] way_sel,
    output logic [BW-1:0]   beat_idx,
    output logic            read_en_cache,
    output logic            write_en_cache,
    output logic            dirty_set,
    output logic            refill,
    output logic            done_cache,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    input  logic            mem_resp_valid,
    output logic            mem_resp_ready
);

    localparam logic [BW-1:0] c_last_beat = BW'(BEATS - 1);
    localparam logic          c_wb        = (WRITE_BACK != 0);

    cache_state_t    r_state, w_next_state;
    logic            r_type, w_next_type;
    logic [WAYS-1:0] r_victim, w_next_victim;
    logic [BW-1:0]   r_beat, w_next_beat;
    logic [BW-1:0]   w_beat_inc;
    logic [WAYS-1:0] w_sel_victim;
    logic            w_advance;
    logic            w_last;
    logic            w_victim_dirty;

    cache_victim_sel #(
        .WAYS (WAYS)
    ) u_victim_sel (
        .clk       (clk),
        .rst       (rst),
        .valid_way (valid_way),
        .advance   (w_advance),
        .victim    (w_sel_victim)
    );

    // Beat counter wraps to zero on the last beat so the next burst starts clean.
    assign w_last         = (r_beat == c_last_beat);
    assign w_beat_inc     = w_last ? '0 : r_beat + 1'b1;
    assign w_victim_dirty = c_wb & (|(dirty_way & w_sel_victim));
    assign beat_idx       = r_beat;

    // State and context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_type   <= 1'b0;
            r_victim <= '0;
            r_beat   <= '0;
        end else begin
            r_state  <= w_next_state;
            r_type   <= w_next_type;
            r_victim <= w_next_victim;
            r_beat   <= w_next_beat;
        end
    end

    // Next-state, context updates and output decode.
    always_comb begin
        w_next_state   = r_state;
        w_next_type    = r_type;
        w_next_victim  = r_victim;
        w_next_beat    = r_beat;
        w_advance      = 1'b0;
        req_ready      = 1'b0;
        way_sel        = '0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        dirty_set      = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_we     = MEM_RD;
        mem_resp_ready = 1'b0;

        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_type  = req_type;
                    w_next_state = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (|hit_way) begin
                    done_cache     = 1'b1;
                    way_sel        = hit_way;
                    read_en_cache  = ~r_type;
                    write_en_cache = r_type;
                    dirty_set      = r_type & c_wb;
                    w_next_state   = (r_type & ~c_wb) ? ST_WRITE_THRU : ST_IDLE;
                end else begin
                    w_next_victim = w_sel_victim;
                    w_advance     = 1'b1;
                    w_next_beat   = '0;
                    w_next_state  = w_victim_dirty ? ST_WRITE_BACK : ST_REFILL_REQ;
                end
            end
            ST_WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = MEM_WR;
                read_en_cache = 1'b1;
                way_sel       = r_victim;
                if (mem_req_ready) begin
                    w_next_beat = w_beat_inc;
                    if (w_last) begin
                        w_next_state = ST_REFILL_REQ;
                    end
                end
            end
            ST_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = MEM_RD;
                if (mem_req_ready) begin
                    w_next_state = ST_REFILL_DATA;
                end
            end
            ST_REFILL_DATA: begin
                mem_resp_ready = 1'b1;
                way_sel        = r_victim;
                if (mem_resp_valid) begin
                    write_en_cache = 1'b1;
                    w_next_beat    = w_beat_inc;
                    if (w_last) begin
                        w_next_state = ST_REFILL_DONE;
                    end
                end
            end
            ST_REFILL_DONE: begin
                refill         = 1'b1;
                done_cache     = 1'b1;
                way_sel        = r_victim;
                read_en_cache  = ~r_type;
                write_en_cache = r_type;
                dirty_set      = r_type & c_wb;
                w_next_state   = (r_type & ~c_wb) ? ST_WRITE_THRU : ST_IDLE;
            end
            ST_WRITE_THRU: begin
                mem_req_valid = 1'b1;
                mem_req_we    = MEM_WR;
                if (mem_req_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_nway
// Description : Directed table-driven bench for cache_ctrl_nway covering
//               write-back, write-through and single-way/single-beat builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_nway;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_type = 1'b0;
    logic [1:0] hit_way = '0;
    logic [1:0] valid_way = '0;
    logic [1:0] dirty_way = '0;
    logic       mem_req_ready = 1'b0;
    logic       mem_resp_valid = 1'b0;

    always #5 clk = ~clk;

    // Instance A: WAYS=2 BEATS=4 write-back
    logic       a_rq, a_rd, a_wr, a_ds, a_rf, a_dn, a_mv, a_mw, a_mr;
    logic [1:0] a_ws, a_bi;
    // Instance B: WAYS=2 BEATS=4 write-through
    logic       b_rq, b_rd, b_wr, b_ds, b_rf, b_dn, b_mv, b_mw, b_mr;
    logic [1:0] b_ws, b_bi;
    // Instance C: WAYS=1 BEATS=1 write-back
    logic       c_rq, c_rd, c_wr, c_ds, c_rf, c_dn, c_mv, c_mw, c_mr;
    logic [0:0] c_ws, c_bi;

    cache_ctrl_nway #(.WAYS(2), .BEATS(4), .WRITE_BACK(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_ready(a_rq),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way), .way_sel(a_ws),
        .beat_idx(a_bi), .read_en_cache(a_rd), .write_en_cache(a_wr), .dirty_set(a_ds),
        .refill(a_rf), .done_cache(a_dn), .mem_req_valid(a_mv), .mem_req_ready(mem_req_ready),
        .mem_req_we(a_mw), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(a_mr));

    cache_ctrl_nway #(.WAYS(2), .BEATS(4), .WRITE_BACK(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_ready(b_rq),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way), .way_sel(b_ws),
        .beat_idx(b_bi), .read_en_cache(b_rd), .write_en_cache(b_wr), .dirty_set(b_ds),
        .refill(b_rf), .done_cache(b_dn), .mem_req_valid(b_mv), .mem_req_ready(mem_req_ready),
        .mem_req_we(b_mw), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(b_mr));

    cache_ctrl_nway #(.WAYS(1), .BEATS(1), .WRITE_BACK(1)) u_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_ready(c_rq),
        .hit_way(hit_way[0:0]), .valid_way(valid_way[0:0]), .dirty_way(dirty_way[0:0]), .way_sel(c_ws),
        .beat_idx(c_bi), .read_en_cache(c_rd), .write_en_cache(c_wr), .dirty_set(c_ds),
        .refill(c_rf), .done_cache(c_dn), .mem_req_valid(c_mv), .mem_req_ready(mem_req_ready),
        .mem_req_we(c_mw), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(c_mr));

    // Observation vectors: {req_ready, way_sel[1:0], beat_idx[1:0], rd, wr, dirty_set, refill, done, mem_req_valid, mem_req_we, mem_resp_ready}
    logic [12:0] obs_a, obs_b, obs_c;
    assign obs_a = {a_rq, a_ws, a_bi, a_rd, a_wr, a_ds, a_rf, a_dn, a_mv, a_mw, a_mr};
    assign obs_b = {b_rq, b_ws, b_bi, b_rd, b_wr, b_ds, b_rf, b_dn, b_mv, b_mw, b_mr};
    assign obs_c = {c_rq, 1'b0, c_ws, 1'b0, c_bi, c_rd, c_wr, c_ds, c_rf, c_dn, c_mv, c_mw, c_mr};

    // Multi-hot hit_way is an illegal stimulus.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(hit_way)) else $error("illegal multi-hot hit_way %b", hit_way);
        end
    end

    typedef struct {
        int          dut;
        bit          chk;
        bit          r;
        bit          rv;
        bit          rt;
        bit [1:0]    hit;
        bit [1:0]    val;
        bit [1:0]    dty;
        bit          mrdy;
        bit          mrsp;
        logic [12:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [12:0] o(bit rq, bit [1:0] ws, bit [1:0] bi, bit rd, bit wr, bit ds,
                                      bit rf, bit dn, bit mv, bit mw, bit mr);
        return {rq, ws, bi, rd, wr, ds, rf, dn, mv, mw, mr};
    endfunction

    localparam logic [12:0] IDL = 13'b1_00_00_00000000;
    localparam logic [12:0] Z   = 13'b0;

    task automatic push(int dut, bit r, bit rv, bit rt, bit [1:0] hit, bit [1:0] val, bit [1:0] dty,
                        bit mrdy, bit mrsp, logic [12:0] e, string nm);
        vec_t v;
        v.dut = dut; v.chk = 1'b1; v.r = r; v.rv = rv; v.rt = rt; v.hit = hit; v.val = val;
        v.dty = dty; v.mrdy = mrdy; v.mrsp = mrsp; v.exp = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic rst_row();
        vec_t v;
        v.dut = 0; v.chk = 1'b0; v.r = 1'b1; v.rv = 1'b0; v.rt = 1'b0; v.hit = '0; v.val = '0;
        v.dty = '0; v.mrdy = 1'b0; v.mrsp = 1'b0; v.exp = Z; v.nm = "reset";
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge; outputs settle before the next rising edge.
    task automatic apply(bit r, bit rv, bit rt, bit [1:0] hit, bit [1:0] val, bit [1:0] dty,
                         bit mrdy, bit mrsp);
        @(negedge clk);
        rst = r; req_valid = rv; req_type = rt; hit_way = hit; valid_way = val;
        dirty_way = dty; mem_req_ready = mrdy; mem_resp_valid = mrsp;
        #2;
    endtask

    task automatic check(string nm, logic [12:0] got, logic [12:0] e);
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, e);
        end
    endtask

    initial begin
        // ---- A: read hit ----
        rst_row();
        push(0,0, 0,0, 2'b00,2'b11,2'b00, 0,0, IDL, "a_reset_state");
        push(0,0, 1,0, 2'b10,2'b11,2'b00, 0,0, IDL, "a_hit_accept");
        push(0,0, 0,0, 2'b10,2'b11,2'b00, 0,0, o(0,2'b10,0,1,0,0,0,1,0,0,0), "a_read_hit_done");
        push(0,0, 0,0, 2'b00,2'b11,2'b00, 0,0, IDL, "a_hit_ready_again");
        // ---- A: clean miss, way 1 invalid ----
        rst_row();
        push(0,0, 1,0, 2'b00,2'b01,2'b00, 0,0, IDL, "a_miss_accept");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,0, Z, "a_miss_compare");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 1,0, o(0,0,0,0,0,0,0,0,1,0,0), "a_refill_req");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,1, o(0,2'b10,0,0,1,0,0,0,0,0,1), "a_data_beat0");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,1, o(0,2'b10,1,0,1,0,0,0,0,0,1), "a_data_beat1");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,0, o(0,2'b10,2,0,0,0,0,0,0,0,1), "a_data_gap");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,1, o(0,2'b10,2,0,1,0,0,0,0,0,1), "a_data_beat2");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,1, o(0,2'b10,3,0,1,0,0,0,0,0,1), "a_data_beat3");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,0, o(0,2'b10,0,1,0,0,1,1,0,0,0), "a_refill_done");
        push(0,0, 0,0, 2'b00,2'b01,2'b00, 0,0, IDL, "a_miss_idle");
        // ---- A: dirty write miss, all valid, round robin ----
        rst_row();
        push(0,0, 1,1, 2'b00,2'b11,2'b11, 0,0, IDL, "a_dm_accept");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, Z, "a_dm_compare");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,2'b01,0,1,0,0,0,0,1,1,0), "a_wb_beat0");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,2'b01,1,1,0,0,0,0,1,1,0), "a_wb_stall1");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,2'b01,1,1,0,0,0,0,1,1,0), "a_wb_stall2");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,2'b01,1,1,0,0,0,0,1,1,0), "a_wb_beat1");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,2'b01,2,1,0,0,0,0,1,1,0), "a_wb_beat2");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,2'b01,3,1,0,0,0,0,1,1,0), "a_wb_beat3");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,0,0,0,0,0,0,0,1,0,0), "a_rr_wait");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,0,0,0,0,0,0,0,1,0,0), "a_rr_accept");
        for (int b = 0; b < 4; b++)
            push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,1, o(0,2'b01,2'(b),0,1,0,0,0,0,0,1), "a_dm_data");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,2'b01,0,0,1,1,1,1,0,0,0), "a_dm_done_dirty");
        push(0,0, 1,0, 2'b00,2'b11,2'b00, 0,0, IDL, "a_m2_accept");
        push(0,0, 0,0, 2'b00,2'b11,2'b00, 0,0, Z, "a_m2_compare");
        push(0,0, 0,0, 2'b00,2'b11,2'b00, 1,0, o(0,0,0,0,0,0,0,0,1,0,0), "a_m2_rr");
        for (int b = 0; b < 4; b++)
            push(0,0, 0,0, 2'b00,2'b11,2'b00, 0,1, o(0,2'b10,2'(b),0,1,0,0,0,0,0,1), "a_m2_data_way1");
        push(0,0, 0,0, 2'b00,2'b11,2'b00, 0,0, o(0,2'b10,0,1,0,0,1,1,0,0,0), "a_m2_done");
        push(0,0, 1,0, 2'b00,2'b11,2'b11, 0,0, IDL, "a_m3_accept");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, Z, "a_m3_compare");
        push(0,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,2'b01,0,1,0,0,0,0,1,1,0), "a_m3_wb_way0");
        // ---- B: write-through ----
        rst_row();
        push(1,0, 1,1, 2'b01,2'b11,2'b11, 0,0, IDL, "b_wh_accept");
        push(1,0, 0,0, 2'b01,2'b11,2'b11, 0,0, o(0,2'b01,0,0,1,0,0,1,0,0,0), "b_write_hit");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,0,0,0,0,0,0,0,1,1,0), "b_wt_wait");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,0,0,0,0,0,0,0,1,1,0), "b_wt_accept");
        push(1,0, 1,1, 2'b00,2'b11,2'b11, 0,0, IDL, "b_wm_accept");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 0,0, Z, "b_wm_compare");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,0,0,0,0,0,0,0,1,0,0), "b_rr_skip_wb");
        for (int b = 0; b < 4; b++)
            push(1,0, 0,0, 2'b00,2'b11,2'b11, 0,1, o(0,2'b01,2'(b),0,1,0,0,0,0,0,1), "b_data");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,2'b01,0,0,1,0,1,1,0,0,0), "b_done_no_dirty");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,0,0,0,0,0,0,0,1,1,0), "b_wt2");
        push(1,0, 0,0, 2'b00,2'b11,2'b11, 0,0, IDL, "b_idle");
        // ---- C: single way, single beat ----
        rst_row();
        push(2,0, 1,0, 2'b00,2'b11,2'b00, 0,0, IDL, "c_accept");
        push(2,0, 0,0, 2'b00,2'b11,2'b00, 0,0, Z, "c_compare");
        push(2,0, 0,0, 2'b00,2'b11,2'b00, 1,0, o(0,0,0,0,0,0,0,0,1,0,0), "c_rr");
        push(2,0, 0,0, 2'b00,2'b11,2'b00, 0,1, o(0,2'b01,0,0,1,0,0,0,0,0,1), "c_one_beat");
        push(2,0, 0,0, 2'b00,2'b11,2'b00, 0,1, o(0,2'b01,0,1,0,0,1,1,0,0,0), "c_done");
        push(2,0, 1,0, 2'b00,2'b11,2'b11, 0,0, IDL, "c_dm_accept");
        push(2,0, 0,0, 2'b00,2'b11,2'b11, 0,0, Z, "c_dm_compare");
        push(2,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,2'b01,0,1,0,0,0,0,1,1,0), "c_wb_one_beat");
        push(2,0, 0,0, 2'b00,2'b11,2'b11, 1,0, o(0,0,0,0,0,0,0,0,1,0,0), "c_dm_rr");
        push(2,0, 0,0, 2'b00,2'b11,2'b11, 0,1, o(0,2'b01,0,0,1,0,0,0,0,0,1), "c_dm_data");
        push(2,0, 0,0, 2'b00,2'b11,2'b11, 0,0, o(0,2'b01,0,1,0,0,1,1,0,0,0), "c_dm_done");

        foreach (tbl[k]) begin
            apply(tbl[k].r, tbl[k].rv, tbl[k].rt, tbl[k].hit, tbl[k].val, tbl[k].dty,
                  tbl[k].mrdy, tbl[k].mrsp);
            if (tbl[k].chk) begin
                case (tbl[k].dut)
                    0:       check(tbl[k].nm, obs_a, tbl[k].exp);
                    1:       check(tbl[k].nm, obs_b, tbl[k].exp);
                    default: check(tbl[k].nm, obs_c, tbl[k].exp);
                endcase
            end
        end

        // ---- A: reset asserted during refill beat 2 abandons the burst ----
        apply(1, 0,0, 2'b00,2'b00,2'b00, 0,0);
        apply(0, 1,0, 2'b00,2'b00,2'b00, 0,0);
        check("r_accept", obs_a, IDL);
        apply(0, 0,0, 2'b00,2'b00,2'b00, 0,0);
        check("r_compare", obs_a, Z);
        apply(0, 0,0, 2'b00,2'b00,2'b00, 1,0);
        check("r_refill_req", obs_a, o(0,0,0,0,0,0,0,0,1,0,0));
        apply(0, 0,0, 2'b00,2'b00,2'b00, 0,1);
        check("r_beat0_way0", obs_a, o(0,2'b01,0,0,1,0,0,0,0,0,1));
        apply(0, 0,0, 2'b00,2'b00,2'b00, 0,1);
        check("r_beat1", obs_a, o(0,2'b01,1,0,1,0,0,0,0,0,1));
        apply(1, 0,0, 2'b00,2'b00,2'b00, 0,1);
        check("r_beat2_at_reset", obs_a, o(0,2'b01,2,0,1,0,0,0,0,0,1));
        apply(0, 0,0, 2'b00,2'b00,2'b00, 1,1);
        check("r_idle_after_reset", obs_a, IDL);
        apply(0, 0,0, 2'b00,2'b00,2'b00, 1,1);
        check("r_idle_hold", obs_a, IDL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
